board_eval: RTL and testbench



---
 rtl/chess_pkg.sv | 64 ++++++
 rtl/piece_value.sv | 59 +++++
 rtl/board_eval.sv | 186 ++++++++++++++++++
 tb/tb_board_eval.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chess_pkg.sv
// Shared piece codes, piece values, register map and FSM states
// for the move-generator / board evaluator family.
package chess_pkg;

  localparam logic signed [7:0] EMPTY    = 8'sd0;
  localparam logic signed [7:0] WPAWN0   = 8'sd1;
  localparam logic signed [7:0] WPAWN7   = 8'sd8;
  localparam logic signed [7:0] WROOK0   = 8'sd9;
  localparam logic signed [7:0] WKNIGHT0 = 8'sd19;
  localparam logic signed [7:0] WBISHOP0 = 8'sd29;
  localparam logic signed [7:0] WQUEEN   = 8'sd39;
  localparam logic signed [7:0] WKING    = 8'sd48;
  localparam logic signed [7:0] BPAWN0   = -8'sd1;
  localparam logic signed [7:0] BPAWN3   = -8'sd4;
  localparam logic signed [7:0] BPAWN7   = -8'sd8;
  localparam logic signed [7:0] BROOK0   = -8'sd9;
  localparam logic signed [7:0] BKNIGHT0 = -8'sd19;
  localparam logic signed [7:0] BBISHOP0 = -8'sd29;
  localparam logic signed [7:0] BQUEEN   = -8'sd39;
  localparam logic signed [7:0] BKING    = -8'sd48;

  // Upper bound of each piece class, on the code magnitude.
  localparam logic [8:0] PAWN_MAX   = 9'd8;
  localparam logic [8:0] ROOK_MAX   = 9'd18;
  localparam logic [8:0] KNIGHT_MAX = 9'd28;
  localparam logic [8:0] BISHOP_MAX = 9'd38;
  localparam logic [8:0] QUEEN_MAX  = 9'd47;
  localparam logic [8:0] KING_CODE  = 9'd48;

  localparam logic signed [31:0] PAWN_VAL   = 32'sd100;
  localparam logic signed [31:0] ROOK_VAL   = 32'sd500;
  localparam logic signed [31:0] KNIGHT_VAL = 32'sd300;
  localparam logic signed [31:0] BISHOP_VAL = 32'sd300;
  localparam logic signed [31:0] QUEEN_VAL  = 32'sd900;
  localparam logic signed [31:0] KING_VAL   = 32'sd20000;
  localparam logic signed [31:0] PST_STEP   = 32'sd5;

  localparam logic signed [31:0] BEST_MIN = 32'sh8000_0000;
  localparam logic signed [31:0] BEST_MAX = 32'sh7FFF_FFFF;

  localparam logic [3:0] REG_CTRL       = 4'd0;
  localparam logic [3:0] REG_BOARD_BASE = 4'd1;
  localparam logic [3:0] REG_SCORE_BASE = 4'd2;
  localparam logic [3:0] REG_COUNT      = 4'd3;
  localparam logic [3:0] REG_SIDE       = 4'd4;
  localparam logic [3:0] REG_BEST_IDX   = 4'd5;
  localparam logic [3:0] REG_BEST_SCORE = 4'd6;
  localparam logic [3:0] REG_STATUS     = 4'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_SCORE,
    S_NEXT
  } state_t;

  function automatic logic [8:0] code_mag(input logic [7:0] c);
    logic [8:0] s;
    s = {c[7], c};
    return c[7] ? (9'd0 - s) : s;
  endfunction

endpackage

// File: rtl/piece_value.sv
// Piece code to signed value map with out-of-range flag.
// BOARD_EVAL_PST_EN adds a pawn advancement bonus from rank y.
module piece_value
  import chess_pkg::*;
(
  input  logic [7:0]         code,
  input  logic [2:0]         y,
  output logic signed [31:0] value,
  output logic               bad
);

  logic [8:0]         mag;
  logic signed [31:0] mat;
  logic               pawn;

  assign mag = code_mag(code);

  always_comb begin
    mat  = '0;
    bad  = 1'b0;
    pawn = 1'b0;
    unique case (1'b1)
      (mag == 9'd0): mat = '0;
      (mag >= 9'd1 && mag <= PAWN_MAX): begin
        mat  = PAWN_VAL;
        pawn = 1'b1;
      end
      (mag > PAWN_MAX && mag <= ROOK_MAX):     mat = ROOK_VAL;
      (mag > ROOK_MAX && mag <= KNIGHT_MAX):   mat = KNIGHT_VAL;
      (mag > KNIGHT_MAX && mag <= BISHOP_MAX): mat = BISHOP_VAL;
      (mag > BISHOP_MAX && mag <= QUEEN_MAX):  mat = QUEEN_VAL;
      (mag == KING_CODE):                      mat = KING_VAL;
      default: bad = 1'b1;
    endcase
  end

`ifdef BOARD_EVAL_PST_EN
  logic signed [31:0] y32;
  logic signed [31:0] bonus;

  assign y32 = $signed({29'd0, y});

  // White pawns gain as they climb, black pawns as they descend.
  always_comb begin
    bonus = '0;
    if (pawn) begin
      if (code[7]) bonus = -(PST_STEP * (32'sd6 - y32));
      else         bonus = PST_STEP * (y32 - 32'sd1);
    end
  end

  assign value = (code[7] ? -mat : mat) + bonus;
`else
  logic unused_pst;
  assign unused_pst = ^{y, pawn};
  assign value = code[7] ? -mat : mat;
`endif

endmodule

// File: rtl/board_eval.sv
// Reads candidate boards over Avalon-MM, writes one material score per board
// and tracks the best one. BOARD_EVAL_PST_EN enables the pawn bonus.
module board_eval
  import chess_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic        slave_waitrequest,
  input  logic [3:0]  slave_address,
  input  logic        slave_read,
  input  logic        slave_write,
  output logic [31:0] slave_readdata,
  input  logic [31:0] slave_writedata,
  input  logic        master_waitrequest,
  output logic [31:0] master_address,
  output logic        master_read,
  output logic        master_write,
  input  logic [31:0] master_readdata,
  input  logic        master_readdatavalid,
  output logic [31:0] master_writedata
);

  state_t             state;
  logic [31:0]        board_base;
  logic [31:0]        score_base;
  logic [7:0]         board_cnt;
  logic               side;
  logic [31:0]        best_idx;
  logic signed [31:0] best_score;
  logic               bad_code;
  logic [31:0]        evaluated;
  logic [7:0]         board;
  logic [5:0]         sq;
  logic signed [31:0] acc;

  logic               busy;
  logic               start;
  logic               cfg_wr;
  logic [5:0]         nxt_sq;
  logic signed [31:0] pv;
  logic               pv_bad;
  logic signed [31:0] acc_nxt;
  logic               better;
  logic               unused_rd;

  assign busy    = (state != S_IDLE);
  assign start   = slave_write && (slave_address == REG_CTRL) && !busy;
  assign cfg_wr  = slave_write && !busy &&
                   (slave_address >= REG_BOARD_BASE) &&
                   (slave_address <= REG_SIDE);
  assign nxt_sq  = sq + 6'd1;
  assign acc_nxt = acc + pv;
  assign better  = side ? (acc < best_score) : (acc > best_score);
  assign unused_rd = ^master_readdata[31:8];

  piece_value u_piece_value (
    .code  (master_readdata[7:0]),
    .y     (sq[5:3]),
    .value (pv),
    .bad   (pv_bad)
  );

  // A control read stalls the host until the current run is finished.
  assign slave_waitrequest = slave_read && (slave_address == REG_CTRL) && busy;

  always_comb begin
    slave_readdata = '0;
    if (slave_read) begin
      case (slave_address)
        REG_CTRL:       slave_readdata = busy ? '0 : evaluated;
        REG_BOARD_BASE: slave_readdata = board_base;
        REG_SCORE_BASE: slave_readdata = score_base;
        REG_COUNT:      slave_readdata = {24'd0, board_cnt};
        REG_SIDE:       slave_readdata = {31'd0, side};
        REG_BEST_IDX:   slave_readdata = best_idx;
        REG_BEST_SCORE: slave_readdata = best_score;
        REG_STATUS:     slave_readdata = {30'd0, bad_code, busy};
        default:        slave_readdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      board_base       <= '0;
      score_base       <= '0;
      board_cnt        <= '0;
      side             <= 1'b0;
      best_idx         <= '1;
      best_score       <= '0;
      bad_code         <= 1'b0;
      evaluated        <= '0;
      board            <= '0;
      sq               <= '0;
      acc              <= '0;
      master_address   <= '0;
      master_read      <= 1'b0;
      master_write     <= 1'b0;
      master_writedata <= '0;
    end else begin
      if (cfg_wr) begin
        case (slave_address)
          REG_BOARD_BASE: board_base <= slave_writedata;
          REG_SCORE_BASE: score_base <= slave_writedata;
          REG_COUNT:      board_cnt  <= slave_writedata[7:0];
          REG_SIDE:       side       <= slave_writedata[0];
          default: ;
        endcase
      end

      unique case (state)
        S_IDLE: begin
          if (start) begin
            bad_code   <= 1'b0;
            evaluated  <= '0;
            board      <= '0;
            sq         <= '0;
            acc        <= '0;
            best_idx   <= '1;
            best_score <= side ? BEST_MAX : BEST_MIN;
            if (board_cnt != 8'd0) begin
              state          <= S_RD_REQ;
              master_read    <= 1'b1;
              master_address <= board_base;
            end
          end
        end

        S_RD_REQ: begin
          if (!master_waitrequest) begin
            master_read <= 1'b0;
            state       <= S_RD_WAIT;
          end
        end

        S_RD_WAIT: begin
          if (master_readdatavalid) begin
            acc <= acc_nxt;
            if (pv_bad) bad_code <= 1'b1;
            if (sq == 6'd63) begin
              state            <= S_WR_SCORE;
              master_write     <= 1'b1;
              master_address   <= score_base + {22'd0, board, 2'b00};
              master_writedata <= acc_nxt;
            end else begin
              sq             <= nxt_sq;
              state          <= S_RD_REQ;
              master_read    <= 1'b1;
              master_address <= board_base + {16'd0, board, nxt_sq, 2'b00};
            end
          end
        end

        S_WR_SCORE: begin
          if (!master_waitrequest) begin
            master_write <= 1'b0;
            evaluated    <= evaluated + 32'd1;
            board        <= board + 8'd1;
            state        <= S_NEXT;
            // Strict compare: on a tie the earlier board stays best.
            if (better) begin
              best_score <= acc;
              best_idx   <= {24'd0, board};
            end
          end
        end

        S_NEXT: begin
          if (board < board_cnt) begin
            sq             <= '0;
            acc            <= '0;
            state          <= S_RD_REQ;
            master_read    <= 1'b1;
            master_address <= board_base + {16'd0, board, 8'd0};
          end else begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_eval.sv
// Directed bench for board_eval: table of evaluation runs plus
// hand sequences for busy writes, bad codes, N=0 and mid-run reset.
module tb_board_eval;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        slave_waitrequest;
  logic [3:0]  slave_address = '0;
  logic        slave_read = 1'b0;
  logic        slave_write = 1'b0;
  logic [31:0] slave_readdata;
  logic [31:0] slave_writedata = '0;
  logic        master_waitrequest = 1'b0;
  logic [31:0] master_address;
  logic        master_read;
  logic        master_write;
  logic [31:0] master_readdata = '0;
  logic        master_readdatavalid = 1'b0;
  logic [31:0] master_writedata;

  always #5 clk = ~clk;

  board_eval dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .slave_waitrequest    (slave_waitrequest),
    .slave_address        (slave_address),
    .slave_read           (slave_read),
    .slave_write          (slave_write),
    .slave_readdata       (slave_readdata),
    .slave_writedata      (slave_writedata),
    .master_waitrequest   (master_waitrequest),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_write         (master_write),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .master_writedata     (master_writedata)
  );

  localparam logic [31:0] SB = 32'h0001_0000;

  logic [31:0] brd [0:383];
  logic [31:0] sc [0:7];
  int          rdcnt [0:383];
  int          slot_sc [0:5] = '{0, 100, 0, 0, -900, 0};
  int          wcnt, strobes, errors, checks, cyc, wr_cyc, rd_cyc, widx;
  bit          rnd, overlap, pend;
  int          pcnt;
  logic [31:0] paddr;

  always @(posedge clk) cyc <= cyc + 1;

  // SDRAM model: random stalls and 0..5 cycle read latency when rnd is set.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 0;
      master_readdatavalid = 1'b0;
      master_waitrequest = 1'b0;
    end else begin
      master_readdatavalid = 1'b0;
      if (pend) begin
        if (pcnt == 0) begin
          master_readdatavalid = 1'b1;
          master_readdata = (paddr[31:2] < 384) ? brd[paddr[10:2]] : 32'd0;
          pend = 0;
        end else pcnt--;
      end
      master_waitrequest = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      if (master_read || master_write) strobes++;
      if (master_read && !master_waitrequest) begin
        if (pend) overlap = 1;
        pend  = 1;
        pcnt  = rnd ? $urandom_range(0, 5) : 0;
        paddr = master_address;
        if (master_address[31:2] < 384) rdcnt[master_address[10:2]]++;
      end
      if (master_write && !master_waitrequest) begin
        wcnt++;
        widx = int'((master_address - SB) >> 2);
        if (master_address >= SB && widx < 8) sc[widx] = master_writedata;
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic reg_wr(logic [3:0] a, logic [31:0] d);
    @(negedge clk);
    slave_address = a;
    slave_writedata = d;
    slave_write = 1'b1;
    @(posedge clk);
    #1 slave_write = 1'b0;
    wr_cyc = cyc;
  endtask

  task automatic reg_rd(logic [3:0] a, output logic [31:0] d, output int waits);
    @(negedge clk);
    slave_address = a;
    slave_read = 1'b1;
    waits = 0;
    d = '0;
    #1;
    while (slave_waitrequest && waits < 40000) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (slave_waitrequest) begin
      checks++;
      errors++;
      $display("FAIL reg_rd_timeout a=%0d: waitrequest %b required 0", a, slave_waitrequest);
    end else begin
      d = slave_readdata;
      rd_cyc = cyc;
    end
    @(posedge clk);
    #1 slave_read = 1'b0;
  endtask

  task automatic put_start(int s);
    int back [8] = '{9, 19, 29, 39, 48, 30, 20, 10};
    for (int i = 0; i < 64; i++) brd[s*64+i] = '0;
    for (int i = 0; i < 8; i++) begin
      brd[s*64+i]    = 32'(back[i]);
      brd[s*64+8+i]  = 32'(i + 1);
      brd[s*64+48+i] = 32'(-(i + 1));
      brd[s*64+56+i] = 32'(-back[i]);
    end
  endtask

  task automatic clear_mon();
    for (int i = 0; i < 384; i++) rdcnt[i] = 0;
    for (int i = 0; i < 8; i++) sc[i] = 32'hDEAD_BEEF;
    wcnt = 0;
    overlap = 0;
  endtask

  task automatic setup(int slot, int n, bit side);
    reg_wr(4'd1, 32'(slot * 256));
    reg_wr(4'd2, SB);
    reg_wr(4'd3, 32'(n));
    reg_wr(4'd4, {31'd0, side});
  endtask

  typedef struct {
    int          slot;
    int          n;
    bit          side;
    bit          rnd;
    int          lat;
    logic [31:0] bidx;
    logic [31:0] bsc;
  } vec_t;

  vec_t        v [7];
  logic [31:0] d;
  int          w, bad;

  initial begin
    v[0] = '{0, 1, 1'b0, 1'b0, 130, 32'd0, 32'd0};
    v[1] = '{0, 2, 1'b0, 1'b0, 260, 32'd1, 32'd100};
    v[2] = '{0, 2, 1'b1, 1'b0, 260, 32'd0, 32'd0};
    v[3] = '{2, 2, 1'b0, 1'b0, 260, 32'd0, 32'd0};
    v[4] = '{2, 2, 1'b1, 1'b0, 260, 32'd0, 32'd0};
    v[5] = '{0, 5, 1'b1, 1'b1, 0, 32'd4, 32'hFFFF_FC7C};
    v[6] = '{0, 5, 1'b0, 1'b1, 0, 32'd1, 32'd100};

    for (int s = 0; s < 6; s++) put_start(s);
    brd[64+51] = '0;
    brd[4*64+3] = '0;
    for (int i = 0; i < 64; i++) brd[5*64+i] = {24'h5A5A5A, brd[5*64+i][7:0]};
    brd[5*64+20] = {24'h5A5A5A, 8'h7F};
    rnd = 0;
    strobes = 0;
    clear_mon();

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_master_read", {31'd0, master_read}, 32'd0);
    chk("rst_master_write", {31'd0, master_write}, 32'd0);
    chk("rst_master_address", master_address, 32'd0);
    chk("rst_master_writedata", master_writedata, 32'd0);
    chk("rst_slave_wait", {31'd0, slave_waitrequest}, 32'd0);
    chk("rst_slave_rdata", slave_readdata, 32'd0);
    for (int r = 0; r < 8; r++) begin
      reg_rd(4'(r), d, w);
      chk($sformatf("rst_reg%0d", r), d, (r == 5) ? 32'hFFFF_FFFF : 32'd0);
    end

    for (int k = 0; k < 7; k++) begin
      rnd = v[k].rnd;
      clear_mon();
      setup(v[k].slot, v[k].n, v[k].side);
      reg_wr(4'd0, 32'd1);
      reg_rd(4'd0, d, w);
      chk($sformatf("v%0d_count", k), d, 32'(v[k].n));
      if (v[k].lat != 0) chk($sformatf("v%0d_latency", k), 32'(rd_cyc - wr_cyc), 32'(v[k].lat));
      reg_rd(4'd5, d, w);
      chk($sformatf("v%0d_best_idx", k), d, v[k].bidx);
      reg_rd(4'd6, d, w);
      chk($sformatf("v%0d_best_score", k), d, v[k].bsc);
      reg_rd(4'd7, d, w);
      chk($sformatf("v%0d_status", k), d, 32'd0);
      chk($sformatf("v%0d_writes", k), 32'(wcnt), 32'(v[k].n));
      for (int b = 0; b < v[k].n; b++)
        chk($sformatf("v%0d_score%0d", k, b), sc[b], 32'(slot_sc[v[k].slot + b]));
      bad = 0;
      for (int i = 0; i < 384; i++) begin
        if (i >= v[k].slot * 64 && i < (v[k].slot + v[k].n) * 64) begin
          if (rdcnt[i] != 1) bad++;
        end else if (rdcnt[i] != 0) bad++;
      end
      chk($sformatf("v%0d_read_once", k), 32'(bad), 32'd0);
      chk($sformatf("v%0d_outstanding", k), {31'd0, overlap}, 32'd0);
    end
    rnd = 0;

    // Config writes and a second start while busy must be dropped.
    clear_mon();
    setup(0, 1, 1'b0);
    reg_wr(4'd0, 32'd1);
    reg_wr(4'd1, 32'hDEAD_0000);
    reg_wr(4'd3, 32'd7);
    reg_wr(4'd0, 32'd1);
    reg_rd(4'd0, d, w);
    chk("busy_count", d, 32'd1);
    reg_rd(4'd1, d, w);
    chk("busy_base_kept", d, 32'd0);
    reg_rd(4'd3, d, w);
    chk("busy_n_kept", d, 32'd1);
    chk("busy_writes", 32'(wcnt), 32'd1);

    // Out-of-range code is sticky until the next start.
    clear_mon();
    setup(5, 1, 1'b0);
    reg_wr(4'd0, 32'd1);
    reg_rd(4'd0, d, w);
    reg_rd(4'd7, d, w);
    chk("bad_status", d, 32'd2);
    chk("bad_score", sc[0], 32'd0);
    setup(0, 1, 1'b0);
    reg_wr(4'd0, 32'd1);
    reg_rd(4'd0, d, w);
    reg_rd(4'd7, d, w);
    chk("bad_cleared", d, 32'd0);

    // N = 0: no bus traffic, best keeps its start values.
    setup(0, 0, 1'b0);
    strobes = 0;
    reg_wr(4'd0, 32'd1);
    repeat (5) @(negedge clk);
    chk("n0_strobes", 32'(strobes), 32'd0);
    reg_rd(4'd0, d, w);
    chk("n0_count", d, 32'd0);
    chk("n0_no_wait", 32'(w), 32'd0);
    reg_rd(4'd5, d, w);
    chk("n0_best_idx", d, 32'hFFFF_FFFF);
    reg_rd(4'd6, d, w);
    chk("n0_best_score", d, 32'h8000_0000);

    // Reset in the middle of a board.
    setup(0, 1, 1'b0);
    reg_wr(4'd0, 32'd1);
    repeat (40) @(negedge clk);
    for (int i = 0; i < 20 && !master_read; i++) @(negedge clk);
    chk("mid_read_active", {31'd0, master_read}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_strobes", {30'd0, master_read, master_write}, 32'd0);
    chk("mid_rst_addr", master_address, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    reg_rd(4'd7, d, w);
    chk("mid_rst_status", d, 32'd0);
    reg_rd(4'd5, d, w);
    chk("mid_rst_best_idx", d, 32'hFFFF_FFFF);
    reg_rd(4'd3, d, w);
    chk("mid_rst_n", d, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
